// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling, mid-bit majority vote and a
// one-deep valid/ready holding register toward the core.
// Optional feature macro: UART_RX_PARITY_EN selects 8E1 framing and adds the
// parity_err output and the PARITY state.
module uart_rx #(
    parameter int unsigned BR   = 115200,
    parameter int unsigned CLKF = 18432000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int unsigned BAUD16  = BR * 16;
    localparam int unsigned CLK_DIV = (BAUD16 == 0) ? 1 : CLKF / BAUD16;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned DIV_REM = (BAUD16 == 0) ? 0 : CLKF % BAUD16;

    if (BR == 0 || CLKF == 0 || CLKF < BAUD16 || DIV_REM != 0) begin : g_bad_cfg
        $fatal(1, "uart_rx: CLKF must be a nonzero integer multiple of 16*BR");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;
`endif

    logic             r_sync1;
    logic             r_sync2;
    logic             w_rxs;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic [3:0]       r_s;
    logic [3:0]       w_s_nxt;
    logic [3:0]       w_s_inc;
    logic [2:0]       r_b;
    logic [2:0]       w_b_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_v7;
    logic             w_v7_nxt;
    logic             r_v8;
    logic             w_v8_nxt;
    logic [7:0]       r_data;
    logic [7:0]       w_data_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_ferr;
    logic             w_ferr_nxt;
    logic             r_ovr;
    logic             w_ovr_nxt;
    logic             w_tick;
    logic             w_vote;
    logic             w_vote_now;
`ifdef UART_RX_PARITY_EN
    logic             r_par_bad;
    logic             w_par_bad_nxt;
    logic             r_perr;
    logic             w_perr_nxt;
`endif

    // Two-flop synchronizer for the asynchronous line; idles high out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs      = r_sync2;
    assign w_tick     = (r_state != StIdle) && (r_div == DIV_W'(CLK_DIV - 1));
    assign w_s_inc    = r_s + 4'd1;
    // Majority of the samples taken as s reaches 7, 8 and 9; decided at 9.
    assign w_vote     = (r_v7 & r_v8) | (r_v7 & w_rxs) | (r_v8 & w_rxs);
    assign w_vote_now = w_tick && (w_s_inc == 4'd9);

    // Next-state, datapath and output-pulse logic of the receive FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_s_nxt     = r_s;
        w_b_nxt     = r_b;
        w_shift_nxt = r_shift;
        w_v7_nxt    = r_v7;
        w_v8_nxt    = r_v8;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_ferr_nxt  = 1'b0;
        w_ovr_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt = r_par_bad;
        w_perr_nxt    = 1'b0;
`endif

        if (r_valid && rx_ready) begin
            w_valid_nxt = 1'b0;
        end

        if (r_state != StIdle) begin
            w_div_nxt = w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                // s wraps 15->0 naturally, so votes stay exactly 16 ticks apart
                // from the start bit onwards.
                w_s_nxt = w_s_inc;
                if (w_s_inc == 4'd7) begin
                    w_v7_nxt = w_rxs;
                end
                if (w_s_inc == 4'd8) begin
                    w_v8_nxt = w_rxs;
                end
            end
        end

        unique case (r_state)
            StIdle: begin
                w_div_nxt = '0;
                w_s_nxt   = '0;
                if (!w_rxs) begin
                    w_state_nxt = StStart;
                end
            end
            StStart: begin
                if (w_vote_now) begin
                    if (w_vote) begin
                        w_state_nxt = StIdle;
                    end else begin
                        w_b_nxt     = '0;
                        w_state_nxt = StData;
                    end
                end
            end
            StData: begin
                if (w_vote_now) begin
                    w_shift_nxt = {w_vote, r_shift[7:1]};
                    w_b_nxt     = r_b + 3'd1;
                    if (r_b == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = StParity;
`else
                        w_state_nxt = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (w_vote_now) begin
                    // Even parity: data ones plus parity bit must be even.
                    w_par_bad_nxt = (^r_shift) ^ w_vote;
                    w_state_nxt   = StStop;
                end
            end
`endif
            StStop: begin
                if (w_vote_now) begin
                    // Return to IDLE at mid-stop so a following start edge is seen.
                    w_state_nxt = StIdle;
`ifdef UART_RX_PARITY_EN
                    w_perr_nxt = r_par_bad;
`endif
                    if (!w_vote) begin
                        w_ferr_nxt = 1'b1;
                    end else if (r_valid && !rx_ready) begin
                        w_ovr_nxt = 1'b1;
                    end else begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State, counters, shift register, holding register and flag pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_div   <= '0;
            r_s     <= '0;
            r_b     <= '0;
            r_shift <= '0;
            r_v7    <= 1'b1;
            r_v8    <= 1'b1;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_s     <= w_s_nxt;
            r_b     <= w_b_nxt;
            r_shift <= w_shift_nxt;
            r_v7    <= w_v7_nxt;
            r_v8    <= w_v8_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
            r_ovr   <= w_ovr_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_nxt;
            r_perr    <= w_perr_nxt;
`endif
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level
// reference model (expected bytes queue and expected flag counts).
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int BIT_CLKS = 160;
    localparam int LAT_NOM  = 1532 + (NBITS - 10) * BIT_CLKS;

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       perr_mon;

    uart_rx #(
        .BR   (115200),
        .CLKF (18432000)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

`ifdef UART_RX_PARITY_EN
    logic parity_err;
    assign perr_mon = parity_err;
`else
    assign perr_mon = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    // Observed side, collected by the monitor.
    logic [7:0]  got_q[$];
    int unsigned load_cyc_q[$];
    int          n_ferr = 0, n_ovr = 0, n_perr = 0, n_wide = 0;
    // Reference model side.
    logic [7:0]  exp_q[$];
    int          e_ferr = 0, e_ovr = 0, e_perr = 0;
    bit          m_full = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: sample #1 after the edge; a load is valid rising or valid held
    // across an accepting edge.
    logic prev_valid = 0, prev_ferr = 0, prev_ovr = 0, prev_perr = 0;
    always @(posedge clk) begin
        logic rdy_edge;
        rdy_edge = rx_ready;
        #1;
        if (rx_valid && (!prev_valid || rdy_edge)) begin
            got_q.push_back(rx_data);
            load_cyc_q.push_back(cyc);
        end
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
        if (perr_mon) n_perr++;
        if ((frame_err && prev_ferr) || (overrun && prev_ovr) || (perr_mon && prev_perr)) n_wide++;
        prev_valid = rx_valid;
        prev_ferr  = frame_err;
        prev_ovr   = overrun;
        prev_perr  = perr_mon;
    end

    // Drive one serial frame; called and returns on a falling clock edge.
    task automatic send_frame(input logic [7:0] d, input int bclk, input bit stop_v,
                              input bit pflip);
        logic [10:0] bits;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
        bits[9]  = (^d) ^ pflip;
        bits[10] = stop_v;
`else
        bits[9]  = stop_v;
`endif
        for (int i = 0; i < NBITS; i++) begin
            rx = bits[i];
            repeat (bclk) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    // Frame-level reference: what the receiver must do with a completed frame.
    task automatic model_frame(input logic [7:0] d, input bit stop_v, input bit pflip);
`ifdef UART_RX_PARITY_EN
        if (pflip) e_perr++;
`endif
        if (!stop_v) begin
            e_ferr++;
        end else if (m_full && !rx_ready) begin
            e_ovr++;
        end else begin
            exp_q.push_back(d);
            if (!rx_ready) m_full = 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, "_nload"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check_val({tag, "_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        got_q.delete();
        exp_q.delete();
        load_cyc_q.delete();
        check_val({tag, "_ferr"}, n_ferr, e_ferr);
        check_val({tag, "_ovr"}, n_ovr, e_ovr);
        check_val({tag, "_perr"}, n_perr, e_perr);
        check_val({tag, "_width"}, n_wide, 0);
    endtask

    initial begin
        int unsigned t0;
        int unsigned lat;
        logic [7:0]  d;
        int          bclk;
        bit          stop_v;
        bit          pflip;

        rx       = 1'b1;
        rx_ready = 1'b1;
        reset_n  = 1'b0;
        idle(5);
        check_val("rst_valid", rx_valid, 0);
        check_val("rst_data", rx_data, 0);
        check_val("rst_ferr", frame_err, 0);
        check_val("rst_ovr", overrun, 0);
        check_val("rst_perr", perr_mon, 0);
        reset_n = 1'b1;
        idle(20);

        // Back-to-back frames at nominal rate.
        t0 = cyc;
        send_frame(8'h55, BIT_CLKS, 1, 0);
        model_frame(8'h55, 1, 0);
        send_frame(8'hA3, BIT_CLKS, 1, 0);
        model_frame(8'hA3, 1, 0);
        idle(300);
        check_val("b2b_loads", 32'(load_cyc_q.size()), 2);
        if (load_cyc_q.size() >= 2) begin
            lat = load_cyc_q[0] - t0;
            check_val("latency_in_range", 32'(lat >= LAT_NOM - 2 && lat <= LAT_NOM + 2), 1);
            check_val("b2b_spacing", load_cyc_q[1] - load_cyc_q[0], NBITS * BIT_CLKS);
        end
        compare_all("b2b");

        // 40-clock low glitch on an idle line.
        rx = 1'b0;
        idle(40);
        rx = 1'b1;
        idle(400);
        check_val("glitch_valid", rx_valid, 0);
        compare_all("glitch");

        // Stop bit driven low.
        send_frame(8'h3C, BIT_CLKS, 0, 0);
        model_frame(8'h3C, 0, 0);
        idle(300);
        check_val("ferr_valid", rx_valid, 0);
        compare_all("ferr");

        // Overrun with the consumer stalled.
        rx_ready = 1'b0;
        send_frame(8'h11, BIT_CLKS, 1, 0);
        model_frame(8'h11, 1, 0);
        idle(100);
        check_val("ovr_hold_valid", rx_valid, 1);
        check_val("ovr_hold_data", rx_data, 8'h11);
        send_frame(8'h22, BIT_CLKS, 1, 0);
        model_frame(8'h22, 1, 0);
        idle(100);
        check_val("ovr_keep_data", rx_data, 8'h11);
        check_val("ovr_keep_valid", rx_valid, 1);
        rx_ready = 1'b1;
        m_full   = 0;
        @(posedge clk);
        #1;
        check_val("accept_clears", rx_valid, 0);
        idle(50);
        compare_all("ovr");

        // Bit period skewed by about +-3%.
        send_frame(8'hFF, 155, 1, 0);
        model_frame(8'hFF, 1, 0);
        idle(300);
        send_frame(8'h00, 165, 1, 0);
        model_frame(8'h00, 1, 0);
        idle(300);
        send_frame(8'h00, 155, 1, 0);
        model_frame(8'h00, 1, 0);
        idle(300);
        send_frame(8'hFF, 165, 1, 0);
        model_frame(8'hFF, 1, 0);
        idle(300);
        compare_all("skew");

        // Reset in the middle of D4 of a frame, then a clean frame.
        rx = 1'b0;
        idle(BIT_CLKS * 5);
        rx = 1'b1;
        idle(BIT_CLKS / 2);
        reset_n = 1'b0;
        #1;
        check_val("midrst_valid", rx_valid, 0);
        check_val("midrst_data", rx_data, 0);
        idle(5);
        reset_n = 1'b1;
        idle(BIT_CLKS * 12);
        send_frame(8'h81, BIT_CLKS, 1, 0);
        model_frame(8'h81, 1, 0);
        idle(300);
        compare_all("midrst");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h81, BIT_CLKS, 1, 1);
        model_frame(8'h81, 1, 1);
        idle(300);
        check_val("par_data", rx_data, 8'h81);
        compare_all("parity");
`endif

        // Randomized frames: byte, rate skew, occasional bad stop and parity.
        for (int i = 0; i < 10; i++) begin
            d      = 8'($urandom_range(0, 255));
            stop_v = ($urandom_range(0, 4) != 0);
            pflip  = ($urandom_range(0, 3) == 0);
            bclk   = stop_v ? int'($urandom_range(155, 165)) : int'($urandom_range(155, 160));
            send_frame(d, bclk, stop_v, pflip);
            model_frame(d, stop_v, pflip);
            idle(int'($urandom_range(250, 400)));
        end
        compare_all("rand");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
